vdp_sprite_select: RTL and testbench
====================================

VDP_SPRITE_SELECT -- requirements
Module: vdp_sprite_select

Interface
REQ-001 The parameter MAX_PER_LINE SHALL default to 8 and set the sprites-per-line limit in mode 2, legal range 4..16.
REQ-002 The parameter SAT_ENTRIES SHALL default to 32 and set the number of attribute entries scanned, legal range 1..32.
REQ-003 The design SHALL use one clock and an asynchronous, active-high reset.
REQ-004 The ports SHALL be as follows, one per line:
- clk  in  1  system clock (85.9 MHz domain)
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse: begin evaluating line_y
- line_y  in  8  target scanline
- sprite_mode2  in  1  1 = mode 2 (terminator 216, limit MAX_PER_LINE); 0 = mode 1 (terminator 208, limit 4)
- sprite_16  in  1  16x16 sprite size
- sprite_mag  in  1  magnify x2
- sat_base  in  10  attribute-table address bits [16:7]
- vram_req  out  1  read request
- vram_addr  out  17  read address
- vram_ack  in  1  one-cycle pulse: vram_rdata valid
- vram_rdata  in  8  read data
- sel_valid  out  1  one-cycle pulse per selected sprite
- sel_slot  out  4  selection order 0..MAX_PER_LINE-1
- sel_num  out  5  attribute entry number
- busy  out  1  evaluation in progress
- done  out  1  one-cycle pulse at end of evaluation
- overflow  out  1  more than the limit of sprites fall on the line
- last_num  out  5  overflow sprite number, else last entry examined

Function
REQ-005 The state machine SHALL have the states IDLE, REQ, WAIT, CHECK and FIN.
REQ-006 IDLE SHALL go to REQ on start, latching line_y, the mode inputs and sat_base, and clearing the entry counter n, the hit count, overflow and last_num.
REQ-007 REQ SHALL assert vram_req with vram_addr = {sat_base, n[4:0], 2'b00} and move to WAIT in the same cycle.
REQ-008 vram_req and vram_addr SHALL be held stable until the cycle in which vram_ack=1; vram_req SHALL be deasserted in the cycle after vram_ack.
REQ-009 On vram_ack, WAIT SHALL register vram_rdata as Y and go to CHECK.
REQ-010 In CHECK, if Y equals the terminator (216 in mode 2, 208 in mode 1), the block SHALL go to FIN with last_num=n and no hit.
REQ-011 The hit test SHALL compute diff = (line_y - Y - 1) mod 256 in 8 bits, so wrap-around is intended and Y=255 hits line 0.
REQ-012 The sprite height SHALL be 8 << (sprite_16 + sprite_mag), i.e. 8, 16 or 32; a hit occurs when diff < height.
REQ-013 On a hit with hit count < limit, the block SHALL pulse sel_valid with sel_slot = hit count and sel_num = n, then increment the hit count.
REQ-014 On a hit with hit count == limit, the block SHALL set overflow=1 and last_num=n, go to FIN, and SHALL NOT pulse sel_valid.
REQ-015 After CHECK with no stop condition, the block SHALL increment n; if n == SAT_ENTRIES-1 it SHALL go to FIN with last_num=n, else return to REQ.
REQ-016 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 overflow and last_num SHALL hold their value until the next start.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 A vram_ack outside WAIT SHALL be ignored.
REQ-021 If start and done fall in the same cycle, the start SHALL be ignored.
REQ-022 Latency with a zero-wait ack (ack in the cycle after req) SHALL be 3 cycles per entry plus 1 cycle for FIN.

Reset
REQ-023 While reset=1, the state SHALL be IDLE and every output SHALL be 0: vram_req, vram_addr, sel_valid, sel_slot, sel_num, busy, done, overflow and last_num.
REQ-024 A reset in mid-evaluation SHALL abort the evaluation immediately, with no done pulse and vram_req dropped asynchronously.

Structure
REQ-025 The terminator values 208 and 216, the mode-1 limit of 4 and the state enumeration SHALL be defined in the shared package vdp_sprite_pkg.
REQ-026 The block SHALL be a single module with no sub-modules; the hit test MAY be a function in vdp_sprite_pkg.

Verification
REQ-027 Scenario: mode 2, 16x16 with magnify, entries 0..3 at Y=50,90,130,170, entry 4 at Y=216, line_y=60 -> a single sel_valid with sel_num=0, done, overflow=0, last_num=4.
REQ-028 Scenario: mode 2, MAX_PER_LINE=8, ten entries at Y=10, line_y=12 -> sel_num 0..7 in slots 0..7, overflow=1, last_num=8.
REQ-029 Scenario: mode 1, six entries at Y=0, 8x8, line_y=3, with a 216 terminator present -> 4 hits, overflow=1, last_num=4, and 216 is not treated as a terminator.
REQ-030 Scenario: entry 0 at Y=255, 8x8, line_y=0 -> hit on entry 0; entry 0 at Y=255, line_y=8 -> no hit.
REQ-031 Scenario: random ack delays of 0..20 cycles -> vram_addr stable while vram_req is high, and the selection result is unchanged.
REQ-032 Scenario: reset asserted in WAIT, then a new start -> no done pulse from the aborted run, and the new run's results are correct.

Source files
------------

// File: rtl/vdp_sprite_pkg.sv
// Shared constants, state encoding and scanline hit test for sprite selection.
package vdp_sprite_pkg;

    localparam logic [7:0]  TERM_MODE1  = 8'd208;
    localparam logic [7:0]  TERM_MODE2  = 8'd216;
    localparam int unsigned MODE1_LIMIT = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        FIN   = 3'd4
    } sel_state_t;

    // A sprite whose top row is y+1 covers line_y when (line_y - y - 1) mod 256 < height.
    function automatic logic sprite_hit(input logic [7:0] line_y,
                                        input logic [7:0] y,
                                        input logic       s16,
                                        input logic       mag);
        logic [7:0] diff;
        logic [1:0] shamt;
        logic [7:0] height;
        diff   = line_y - y - 8'd1;
        shamt  = {1'b0, s16} + {1'b0, mag};
        height = 8'd8 << shamt;
        return diff < height;
    endfunction

endpackage

// File: rtl/vdp_sprite_select.sv
// Scans the sprite attribute table for one scanline and reports the sprites that land on it.
module vdp_sprite_select
    import vdp_sprite_pkg::*;
#(
    parameter int unsigned MAX_PER_LINE = 8,
    parameter int unsigned SAT_ENTRIES  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  line_y,
    input  logic        sprite_mode2,
    input  logic        sprite_16,
    input  logic        sprite_mag,
    input  logic [9:0]  sat_base,
    output logic        vram_req,
    output logic [16:0] vram_addr,
    input  logic        vram_ack,
    input  logic [7:0]  vram_rdata,
    output logic        sel_valid,
    output logic [3:0]  sel_slot,
    output logic [4:0]  sel_num,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [4:0]  last_num
);

    localparam logic [4:0] LAST_ENTRY = 5'(SAT_ENTRIES - 1);
    localparam logic [4:0] MODE2_LIM  = 5'(MAX_PER_LINE);
    localparam logic [4:0] MODE1_LIM  = 5'(MODE1_LIMIT);

    sel_state_t state;
    logic [7:0] line_q;
    logic       mode2_q;
    logic       s16_q;
    logic       mag_q;
    logic [9:0] base_q;
    logic [4:0] n;
    logic [4:0] hit_cnt;
    logic [7:0] y_q;

    logic [4:0] n_next_c;
    logic [4:0] limit_c;
    logic [7:0] term_c;
    logic       hit_c;

    // Per-entry decode of the latched evaluation parameters.
    always_comb begin
        n_next_c = n + 5'd1;
        limit_c  = mode2_q ? MODE2_LIM : MODE1_LIM;
        term_c   = mode2_q ? TERM_MODE2 : TERM_MODE1;
        hit_c    = sprite_hit(line_q, y_q, s16_q, mag_q);
    end

    // Evaluation sequencer: fetch Y of each entry, test it, emit selections.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            line_q    <= 8'd0;
            mode2_q   <= 1'b0;
            s16_q     <= 1'b0;
            mag_q     <= 1'b0;
            base_q    <= 10'd0;
            n         <= 5'd0;
            hit_cnt   <= 5'd0;
            y_q       <= 8'd0;
            vram_req  <= 1'b0;
            vram_addr <= 17'd0;
            sel_valid <= 1'b0;
            sel_slot  <= 4'd0;
            sel_num   <= 5'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            last_num  <= 5'd0;
        end else begin
            sel_valid <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        line_q    <= line_y;
                        mode2_q   <= sprite_mode2;
                        s16_q     <= sprite_16;
                        mag_q     <= sprite_mag;
                        base_q    <= sat_base;
                        n         <= 5'd0;
                        hit_cnt   <= 5'd0;
                        overflow  <= 1'b0;
                        last_num  <= 5'd0;
                        vram_req  <= 1'b1;
                        vram_addr <= {sat_base, 5'd0, 2'b00};
                        busy      <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (vram_ack) begin
                        y_q      <= vram_rdata;
                        vram_req <= 1'b0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (y_q == term_c) begin
                        last_num <= n;
                        done     <= 1'b1;
                        state    <= FIN;
                    end else if (hit_c && (hit_cnt == limit_c)) begin
                        overflow <= 1'b1;
                        last_num <= n;
                        done     <= 1'b1;
                        state    <= FIN;
                    end else begin
                        if (hit_c) begin
                            sel_valid <= 1'b1;
                            sel_slot  <= hit_cnt[3:0];
                            sel_num   <= n;
                            hit_cnt   <= hit_cnt + 5'd1;
                        end
                        if (n == LAST_ENTRY) begin
                            last_num <= n;
                            done     <= 1'b1;
                            state    <= FIN;
                        end else begin
                            n         <= n_next_c;
                            vram_req  <= 1'b1;
                            vram_addr <= {base_q, n_next_c, 2'b00};
                            state     <= REQ;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    vram_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdp_sprite_select.sv
// Directed bench for vdp_sprite_select with a VRAM responder of configurable ack delay.
module tb_vdp_sprite_select;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  line_y = 8'd0;
    logic        sprite_mode2 = 1'b0;
    logic        sprite_16 = 1'b0;
    logic        sprite_mag = 1'b0;
    logic [9:0]  sat_base = 10'd0;
    logic        vram_req;
    logic [16:0] vram_addr;
    logic        vram_ack = 1'b0;
    logic [7:0]  vram_rdata = 8'd0;
    logic        sel_valid;
    logic [3:0]  sel_slot;
    logic [4:0]  sel_num;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [4:0]  last_num;

    vdp_sprite_select #(.MAX_PER_LINE(8), .SAT_ENTRIES(32)) dut (
        .clk(clk), .reset(reset), .start(start), .line_y(line_y),
        .sprite_mode2(sprite_mode2), .sprite_16(sprite_16), .sprite_mag(sprite_mag),
        .sat_base(sat_base), .vram_req(vram_req), .vram_addr(vram_addr),
        .vram_ack(vram_ack), .vram_rdata(vram_rdata), .sel_valid(sel_valid),
        .sel_slot(sel_slot), .sel_num(sel_num), .busy(busy), .done(done),
        .overflow(overflow), .last_num(last_num)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0][7:0] ys;
        logic [3:0]       nys;
        logic [7:0]       fill;
        logic             mode2;
        logic             s16;
        logic             mag;
        logic [7:0]       line;
        logic [9:0]       base;
        logic [3:0]       nhits;
        logic [7:0][4:0]  nums;
        logic             ovf;
        logic [4:0]       last;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int ack_lo = 0;
    int ack_hi = 0;
    logic [7:0] sat_mem [32];
    logic [9:0] cur_base = 10'd0;
    logic [8:0] sel_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Record every selection and count done pulses.
    always @(negedge clk) begin
        if (sel_valid) sel_q.push_back({sel_slot, sel_num});
        if (done) done_cnt++;
    end

    // VRAM responder: ack after a random delay, checking the request stays put meanwhile.
    initial begin
        logic [16:0] cap;
        int d;
        bit ok;
        forever begin
            @(posedge clk); #1;
            if (vram_req && !reset) begin
                cap = vram_addr;
                check("addr_base", 32'(cap[16:7]), 32'(cur_base));
                check("addr_low", 32'(cap[1:0]), 32'd0);
                d = $urandom_range(ack_hi, ack_lo);
                ok = 1'b1;
                @(posedge clk); #1;
                for (int k = 0; k < d; k++) begin
                    if (reset) begin ok = 1'b0; break; end
                    check("addr_stable", 32'(vram_addr), 32'(cap));
                    check("req_held", 32'(vram_req), 32'd1);
                    @(posedge clk); #1;
                end
                if (ok && !reset) begin
                    check("req_at_ack", 32'(vram_req), 32'd1);
                    vram_rdata = sat_mem[cap[6:2]];
                    vram_ack = 1'b1;
                    @(posedge clk); #1;
                    vram_ack = 1'b0;
                    check("req_dropped", 32'(vram_req), 32'd0);
                end
            end
        end
    end

    function automatic vec_t mk(input logic mode2, input logic s16, input logic mag,
                                input logic [7:0] line, input logic [7:0] fill,
                                input logic [9:0] base);
        vec_t v;
        v = '0;
        v.mode2 = mode2; v.s16 = s16; v.mag = mag;
        v.line = line; v.fill = fill; v.base = base;
        return v;
    endfunction

    task automatic load_mem(input vec_t v);
        for (int i = 0; i < 32; i++) begin
            if (i < int'(v.nys)) sat_mem[i] = v.ys[4'(i)];
            else sat_mem[i] = v.fill;
        end
        cur_base = v.base;
    endtask

    // Launch one evaluation and compare its selections and final status.
    task automatic run_vec(input vec_t v, input string tag, input bit mid_start,
                           input bit start_at_done, output int cyc);
        bit got;
        load_mem(v);
        sel_q.delete();
        @(posedge clk); #1;
        line_y = v.line; sprite_mode2 = v.mode2; sprite_16 = v.s16;
        sprite_mag = v.mag; sat_base = v.base; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        line_y = ~v.line; sprite_mode2 = ~v.mode2; sprite_16 = ~v.s16;
        sprite_mag = ~v.mag; sat_base = ~v.base;
        cyc = 0; got = 1'b0;
        while (cyc < 3000 && !got) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
            else if (mid_start && cyc == 5) start = 1'b1;
            else start = 1'b0;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        if (!got) return;
        if (start_at_done) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, "_start_at_done_busy"}, 32'(busy), 32'd0);
            @(negedge clk);
            check({tag, "_start_at_done_req"}, 32'(vram_req), 32'd0);
            check({tag, "_start_at_done_busy2"}, 32'(busy), 32'd0);
        end else begin
            @(negedge clk);
        end
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'(v.ovf));
        check({tag, "_last_num"}, 32'(last_num), 32'(v.last));
        check({tag, "_nhits"}, 32'(sel_q.size()), 32'(v.nhits));
        for (int i = 0; i < int'(v.nhits) && i < sel_q.size(); i++)
            check({tag, "_sel"}, 32'(sel_q[i]), 32'({4'(i), v.nums[3'(i)]}));
        repeat (3) @(negedge clk);
        check({tag, "_overflow_hold"}, 32'(overflow), 32'(v.ovf));
        check({tag, "_last_hold"}, 32'(last_num), 32'(v.last));
    endtask

    initial begin
        vec_t v;
        int cyc;
        int dc;

        // Vector table: SAT contents, mode, line and hand-computed results.
        v = mk(1, 1, 1, 8'd60, 8'd0, 10'h155);
        v.ys[0] = 8'd50; v.ys[1] = 8'd90; v.ys[2] = 8'd130; v.ys[3] = 8'd170; v.ys[4] = 8'd216;
        v.nys = 4'd5; v.nhits = 4'd1; v.nums[0] = 5'd0; v.last = 5'd4;
        vecs[0] = v;
        v = mk(1, 0, 0, 8'd12, 8'd216, 10'h003);
        for (int i = 0; i < 10; i++) v.ys[4'(i)] = 8'd10;
        for (int i = 0; i < 8; i++) v.nums[3'(i)] = 5'(i);
        v.nys = 4'd10; v.nhits = 4'd8; v.ovf = 1'b1; v.last = 5'd8;
        vecs[1] = v;
        v = mk(0, 0, 0, 8'd3, 8'd208, 10'h2a0);
        v.ys[6] = 8'd216; v.nys = 4'd7;
        for (int i = 0; i < 4; i++) v.nums[3'(i)] = 5'(i);
        v.nhits = 4'd4; v.ovf = 1'b1; v.last = 5'd4;
        vecs[2] = v;
        v = mk(0, 0, 0, 8'd3, 8'd208, 10'h001);
        v.ys[2] = 8'd216; v.nys = 4'd6;
        v.nums[0] = 5'd0; v.nums[1] = 5'd1; v.nums[2] = 5'd3; v.nums[3] = 5'd4;
        v.nhits = 4'd4; v.ovf = 1'b1; v.last = 5'd5;
        vecs[3] = v;
        v = mk(1, 0, 0, 8'd0, 8'd216, 10'h3ff);
        v.ys[0] = 8'd255; v.nys = 4'd1; v.nhits = 4'd1; v.last = 5'd1;
        vecs[4] = v;
        v = mk(1, 0, 0, 8'd8, 8'd216, 10'h3ff);
        v.ys[0] = 8'd255; v.nys = 4'd1; v.last = 5'd1;
        vecs[5] = v;
        v = mk(0, 0, 0, 8'd20, 8'd100, 10'h0f0);
        v.last = 5'd31;
        vecs[6] = v;
        v = mk(1, 1, 0, 8'd26, 8'd216, 10'h010);
        v.ys[0] = 8'd10; v.ys[1] = 8'd9; v.ys[2] = 8'd26; v.ys[3] = 8'd25; v.nys = 4'd4;
        v.nhits = 4'd2; v.nums[0] = 5'd0; v.nums[1] = 5'd3; v.last = 5'd4;
        vecs[7] = v;
        v = mk(1, 0, 1, 8'd210, 8'd216, 10'h020);
        v.ys[0] = 8'd208; v.nys = 4'd1; v.nhits = 4'd1; v.last = 5'd1;
        vecs[8] = v;
        v = mk(0, 0, 0, 8'd210, 8'd0, 10'h040);
        v.ys[0] = 8'd208; v.nys = 4'd1; v.last = 5'd0;
        vecs[9] = v;
        v = mk(1, 1, 1, 8'd60, 8'd216, 10'h080);
        v.ys[0] = 8'd28; v.ys[1] = 8'd27; v.nys = 4'd2; v.nhits = 4'd1; v.last = 5'd2;
        vecs[10] = v;
        v = mk(1, 0, 0, 8'd12, 8'd216, 10'h100);
        for (int i = 0; i < 8; i++) begin v.ys[4'(i)] = 8'd10; v.nums[3'(i)] = 5'(i); end
        v.nys = 4'd8; v.nhits = 4'd8; v.last = 5'd8;
        vecs[11] = v;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_req", 32'(vram_req), 32'd0);
        check("rst_addr", 32'(vram_addr), 32'd0);
        check("rst_sel", 32'({sel_valid, sel_slot, sel_num}), 32'd0);
        check("rst_status", 32'({busy, done, overflow, last_num}), 32'd0);
        reset = 1'b0;

        // Table pass with zero-wait acks.
        ack_lo = 0; ack_hi = 0;
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i), 1'b0, 1'b0, cyc);
            if (i == 0) check("latency_5_entries", 32'(cyc), 32'd16);
            if (i == 6) check("latency_32_entries", 32'(cyc), 32'd97);
        end

        // Random ack delays with a stray start mid-run; results must not move.
        ack_lo = 0; ack_hi = 20;
        run_vec(vecs[1], "rand1", 1'b1, 1'b0, cyc);
        run_vec(vecs[3], "rand3", 1'b1, 1'b0, cyc);
        run_vec(vecs[7], "rand7", 1'b0, 1'b0, cyc);

        // Start coinciding with done is dropped.
        ack_lo = 0; ack_hi = 0;
        run_vec(vecs[4], "startdone", 1'b0, 1'b1, cyc);

        // Reset while waiting for an ack aborts without a done pulse.
        ack_lo = 30; ack_hi = 30;
        load_mem(vecs[1]);
        @(posedge clk); #1;
        line_y = vecs[1].line; sprite_mode2 = 1'b1; sprite_16 = 1'b0; sprite_mag = 1'b0;
        sat_base = vecs[1].base; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_req_before", 32'(vram_req), 32'd1);
        check("abort_busy_before", 32'(busy), 32'd1);
        dc = done_cnt;
        reset = 1'b1;
        #1;
        check("abort_req_async", 32'(vram_req), 32'd0);
        check("abort_outputs", 32'({vram_addr, busy, done, overflow, last_num, sel_valid}), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(dc));
        check("abort_idle", 32'(busy), 32'd0);
        ack_lo = 0; ack_hi = 0;
        run_vec(vecs[0], "after_abort", 1'b0, 1'b0, cyc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
